instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache; the responder end of the fetch interface driven by the program counter register.
- Returns the instruction at Address and raises Hit.
- The PC register samples Hit on the falling edge of Clock and advances only when Hit=1.
- On a miss, refills one line from backing memory over a req/ready beat handshake.

---
 rtl/instr_cache_pkg.sv | 24 ++
 rtl/instr_cache_if.sv | 28 ++
 rtl/instr_cache_array.sv | 65 ++++++
 rtl/instr_cache.sv | 128 ++++++++++++
 tb/tb_instr_cache.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_cache_pkg.sv
// Shared types and field-width helpers for the instruction cache and its storage array.
package instr_cache_pkg;

  localparam int INSTR_W  = 32;
  localparam int OFFSET_W = 2;

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  function automatic int word_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int addr_w, input int num_lines, input int words_per_line);
    return addr_w - OFFSET_W - word_bits(words_per_line) - index_bits(num_lines);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled for port connection.
interface instr_cache_if
  import instr_cache_pkg::*;
#(
  parameter int ADDR_W = 64
);

  logic [ADDR_W-1:0]  Address;
  logic               Flush;
  logic               Hit;
  logic [INSTR_W-1:0] Instruction;
  logic               Misalign;
  logic               Mem_Req;
  logic [ADDR_W-1:0]  Mem_Addr;
  logic               Mem_Ready;
  logic [INSTR_W-1:0] Mem_Data;

  modport slave (
    input  Address, Flush, Mem_Ready, Mem_Data,
    output Hit, Instruction, Misalign, Mem_Req, Mem_Addr
  );

  modport master (
    output Address, Flush, Mem_Ready, Mem_Data,
    input  Hit, Instruction, Misalign, Mem_Req, Mem_Addr
  );

endinterface

// File: rtl/instr_cache_array.sv
// Direct-mapped line storage: data, tag and valid arrays with one write port and a combinational read.
module instr_cache_array
  import instr_cache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 56,
  parameter int DATA_W         = INSTR_W,
  localparam int IDX_W         = index_bits(NUM_LINES),
  localparam int WORD_W        = word_bits(WORDS_PER_LINE)
)
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic              commit_i,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [IDX_W-1:0]  rd_index_i,
  input  logic [WORD_W-1:0] rd_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;

  // Data and tags carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
    end
    if (commit_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (commit_i) begin
      valid_d[wr_index_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = data_q[rd_index_i][rd_word_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-latency lookup, line refill over a req/ready beat handshake.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
)
(
  input  logic          Clock,
  input  logic          Reset_n,
  instr_cache_if.slave  bus
);

  localparam int WORD_W   = word_bits(WORDS_PER_LINE);
  localparam int IDX_W    = index_bits(NUM_LINES);
  localparam int TAG_W    = tag_bits(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_LSB = OFFSET_W + WORD_W;
  localparam int LINE_W   = ADDR_W - LINE_LSB;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;

  logic                misalign;
  logic [WORD_W-1:0]   fetch_word;
  logic [IDX_W-1:0]    fetch_idx;
  logic [TAG_W-1:0]    fetch_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;

  logic [INSTR_W-1:0]  rd_data;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                lookup_hit;
  logic                clear;
  logic                wr_en;
  logic                commit;

  assign misalign   = |bus.Address[OFFSET_W-1:0];
  assign fetch_word = bus.Address[LINE_LSB-1:OFFSET_W];
  assign fetch_idx  = bus.Address[LINE_LSB+IDX_W-1:LINE_LSB];
  assign fetch_tag  = bus.Address[ADDR_W-1:LINE_LSB+IDX_W];

  // The latched line number holds both the victim index and the tag to commit.
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[LINE_W-1:IDX_W];

  instr_cache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W),
    .DATA_W         (INSTR_W)
  ) u_array (
    .clk_i      (Clock),
    .rst_ni     (Reset_n),
    .clear_i    (clear),
    .wr_en_i    (wr_en),
    .commit_i   (commit),
    .wr_index_i (fill_idx),
    .wr_word_i  (beat_q),
    .wr_data_i  (bus.Mem_Data),
    .wr_tag_i   (fill_tag),
    .rd_index_i (fetch_idx),
    .rd_word_i  (fetch_word),
    .rd_data_o  (rd_data),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid)
  );

  assign lookup_hit = (state_q == IDLE) && rd_valid && (rd_tag == fetch_tag)
                      && !misalign && !bus.Flush;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    clear   = 1'b0;
    wr_en   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Flush) begin
          clear = 1'b1;
        end else if (!lookup_hit && !misalign) begin
          line_d  = bus.Address[ADDR_W-1:LINE_LSB];
          beat_d  = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        // Flush wins over a beat arriving in the same cycle; that beat is dropped.
        if (bus.Flush) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (bus.Mem_Ready) begin
          wr_en  = 1'b1;
          beat_d = beat_q + WORD_W'(1);
          if (beat_q == LAST_BEAT) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  assign bus.Hit         = lookup_hit;
  assign bus.Instruction = lookup_hit ? rd_data : '0;
  assign bus.Misalign    = misalign;
  assign bus.Mem_Req     = (state_q == REFILL);
  assign bus.Mem_Addr    = (state_q == REFILL) ? {line_q, beat_q, {OFFSET_W{1'b0}}} : '0;

endmodule

// File: tb/tb_instr_cache.sv
// Directed and randomized bench for instr_cache against a line-level behavioural cache model.
module tb_instr_cache;

  localparam int ADDR_W = 64;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] epoch = 8'h00;
  int         checks = 0;
  int         errors = 0;

  logic        mv   [16];
  logic [63:0] mtag [16];
  logic [31:0] md   [16][4];

  instr_cache_if #(.ADDR_W(ADDR_W)) bus ();

  instr_cache #(
    .ADDR_W         (ADDR_W),
    .NUM_LINES      (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [63:0] a, input logic [7:0] ep);
    logic [31:0] w;
    w = ((32'(a[3:2]) + 32'd1) * 32'h11) + {a[27:4], 8'h00};
    return w ^ {ep, 24'h000000};
  endfunction

  assign bus.Mem_Data = memdata(bus.Mem_Addr, epoch);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Presents one fetch; on a miss, serves the refill and checks every beat and the final hit.
  task automatic fetch(input logic [63:0] a, input bit use_pat, input logic [31:0] pat, input bit wander);
    int          idx, word, beat, cyc;
    logic [63:0] tag, base;
    bit          mis, exp_hit, rdy;
    idx  = int'((a >> 4) % 16);
    word = int'((a >> 2) % 4);
    tag  = a >> 8;
    base = a - (a % 16);
    mis  = (a % 4) != 0;
    bus.Address = a; bus.Flush = 1'b0; bus.Mem_Ready = 1'b0;
    @(negedge clk);
    exp_hit = !mis && mv[idx] && (mtag[idx] == tag);
    check("misalign", 64'(bus.Misalign), 64'(mis));
    check("lookup_hit", 64'(bus.Hit), 64'(exp_hit));
    check("lookup_instr", 64'(bus.Instruction), exp_hit ? 64'(md[idx][word]) : 64'h0);
    check("idle_req", 64'(bus.Mem_Req), 64'h0);
    if (mis) begin
      for (int k = 0; k < 3; k++) begin
        step();
        @(negedge clk);
        check("mis_req", 64'(bus.Mem_Req), 64'h0);
        check("mis_hit", 64'(bus.Hit), 64'h0);
      end
      step();
      return;
    end
    step();
    if (exp_hit) return;
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 64) begin
      rdy = use_pat ? pat[cyc % 32] : ($urandom_range(0, 3) != 0);
      bus.Mem_Ready = rdy;
      if (wander) bus.Address = 64'($urandom_range(0, 255)) * 4;
      @(negedge clk);
      check("refill_req", 64'(bus.Mem_Req), 64'h1);
      check("refill_addr", bus.Mem_Addr, base + 64'(4 * beat));
      check("refill_hit", 64'(bus.Hit), 64'h0);
      if (rdy) begin
        md[idx][beat] = memdata(base + 64'(4 * beat), epoch);
        beat++;
      end
      cyc++;
      step();
    end
    if (beat < 4) check("refill_timeout", 64'(beat), 64'd4);
    mv[idx] = 1'b1; mtag[idx] = tag;
    bus.Mem_Ready = 1'b0; bus.Address = a;
    @(negedge clk);
    check("done_req", 64'(bus.Mem_Req), 64'h0);
    check("done_hit", 64'(bus.Hit), 64'h1);
    check("done_instr", 64'(bus.Instruction), 64'(md[idx][word]));
    step();
  endtask

  task automatic flush_idle();
    bus.Flush = 1'b1; bus.Mem_Ready = 1'b0;
    @(negedge clk);
    check("flush_hit", 64'(bus.Hit), 64'h0);
    check("flush_req", 64'(bus.Mem_Req), 64'h0);
    step();
    bus.Flush = 1'b0;
    model_flush();
  endtask

  task automatic refill_abort(input logic [63:0] a, input int nbeats);
    logic [63:0] base;
    base = a - (a % 16);
    bus.Address = a; bus.Flush = 1'b0; bus.Mem_Ready = 1'b0;
    @(negedge clk);
    check("abort_miss", 64'(bus.Hit), 64'h0);
    step();
    for (int b = 0; b < nbeats; b++) begin
      bus.Mem_Ready = 1'b1;
      @(negedge clk);
      check("abort_addr", bus.Mem_Addr, base + 64'(4 * b));
      step();
    end
    bus.Flush = 1'b1; bus.Mem_Ready = 1'b1;
    @(negedge clk);
    check("abort_req_before", 64'(bus.Mem_Req), 64'h1);
    check("abort_addr_last", bus.Mem_Addr, base + 64'(4 * nbeats));
    step();
    bus.Flush = 1'b0; bus.Mem_Ready = 1'b0;
    model_flush();
  endtask

  initial begin
    logic [63:0] a;
    int          r;
    bus.Address = '0; bus.Flush = 1'b0; bus.Mem_Ready = 1'b0;
    model_flush();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_hit", 64'(bus.Hit), 64'h0);
    check("rst_req", 64'(bus.Mem_Req), 64'h0);
    check("rst_addr", bus.Mem_Addr, 64'h0);
    check("rst_misalign", 64'(bus.Misalign), 64'h0);
    bus.Flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First fill of line 0 with memory always ready.
    fetch(64'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("t1_word0", 64'(bus.Instruction), 64'h11);
    step();
    fetch(64'h8, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t1_word2_hit", 64'(bus.Hit), 64'h1);
    check("t1_word2", 64'(bus.Instruction), 64'h33);
    step();

    // Ready pattern 1,0,0,1,1,0,1 then all words read back.
    fetch(64'h40, 1'b1, 32'h0000_0059, 1'b0);
    fetch(64'h44, 1'b0, 32'h0, 1'b0);
    fetch(64'h48, 1'b0, 32'h0, 1'b0);
    fetch(64'h4C, 1'b0, 32'h0, 1'b0);

    // Conflict on index 0.
    fetch(64'h100, 1'b1, 32'hFFFF_FFFF, 1'b0);
    fetch(64'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Flush while idle, then flush mid-refill and refetch.
    fetch(64'h0, 1'b0, 32'h0, 1'b0);
    flush_idle();
    fetch(64'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    epoch = 8'h5A;
    refill_abort(64'h84, 2);
    fetch(64'h84, 1'b1, 32'hFFFF_FFFF, 1'b0);

    fetch(64'h6, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a refill.
    fetch(64'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    bus.Address = 64'h200; bus.Mem_Ready = 1'b0;
    @(negedge clk);
    check("rr_miss", 64'(bus.Hit), 64'h0);
    step();
    bus.Mem_Ready = 1'b1;
    @(negedge clk);
    check("rr_req_on", 64'(bus.Mem_Req), 64'h1);
    step();
    bus.Mem_Ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rr_req_async", 64'(bus.Mem_Req), 64'h0);
    check("rr_addr_async", bus.Mem_Addr, 64'h0);
    check("rr_hit_async", 64'(bus.Hit), 64'h0);
    model_flush();
    bus.Flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    fetch(64'h0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        flush_idle();
      end else begin
        if (r == 1) epoch = 8'($urandom);
        if (r <= 7) a = 64'($urandom_range(0, 255)) * 4;
        else a = {$urandom, $urandom} & ~64'h3;
        if (r == 11) a = a | 64'h2;
        fetch(a, 1'b0, 32'h0, r == 5);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
